// File: rtl/pipeline_feeder.sv
// Burst feeder: buffers words in a FIFO and streams bursts downstream with a
// ready-stall timeout. Optional beat counter enabled by PIPELINE_FEEDER_STATS_EN.
module pipeline_feeder #(
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 10
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               wr_en,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    output logic                               wr_full,
    input  logic                               start,
    input  logic [$clog2(FIFO_DEPTH+1)-1:0]    burst_len,
    output logic                               out_valid,
    output logic [DATA_WIDTH-1:0]              out_data,
    input  logic                               out_ready,
    input  logic                               err_clear,
    output logic                               busy,
    output logic                               done,
`ifdef PIPELINE_FEEDER_STATS_EN
    output logic [15:0]                        sent_count,
`endif
    output logic                               error
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_ERROR
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      r_beats_left;
    logic [STALL_W-1:0]    r_stall_cnt;
    logic                  r_done;

    logic w_empty;
    logic w_wr_accept;
    logic w_pop;
    logic w_stall;

    assign w_empty     = (r_count == '0);
    assign wr_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign out_valid   = (r_state == ST_SEND) && !w_empty;
    assign out_data    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign busy        = (r_state != ST_IDLE);
    assign error       = (r_state == ST_ERROR);
    assign done        = r_done;

    // A full FIFO refuses writes even when the same cycle pops a word.
    assign w_wr_accept = wr_en && !wr_full && (r_state != ST_ERROR);
    assign w_pop       = out_valid && out_ready;
    assign w_stall     = out_valid && !out_ready;

    // NOTE: storage array carries no reset; occupancy count alone defines validity.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_beats_left <= '0;
            r_stall_cnt  <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_stall) begin
                if (r_stall_cnt != STALL_W'(TIMEOUT_CYCLES)) begin
                    r_stall_cnt <= r_stall_cnt + 1'b1;
                end
            end else begin
                r_stall_cnt <= '0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start && (burst_len != '0)) begin
                        r_beats_left <= burst_len;
                        r_state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_pop) begin
                        r_beats_left <= r_beats_left - 1'b1;
                        if (r_beats_left == CNT_W'(1)) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end else if (w_stall && (r_stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1))) begin
                        r_state <= ST_ERROR;
                    end
                end
                ST_ERROR: begin
                    // Recovery discards everything buffered so the next burst starts clean.
                    if (err_clear) begin
                        r_state      <= ST_IDLE;
                        r_wr_ptr     <= '0;
                        r_rd_ptr     <= '0;
                        r_count      <= '0;
                        r_beats_left <= '0;
                        r_stall_cnt  <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef PIPELINE_FEEDER_STATS_EN
    logic [15:0] r_sent_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sent_count <= '0;
        end else if (w_pop) begin
            r_sent_count <= r_sent_count + 16'd1;
        end
    end

    assign sent_count = r_sent_count;
`endif

endmodule

// File: tb/tb_pipeline_feeder.sv
// Directed self-checking bench for pipeline_feeder (default parameters).
module tb_pipeline_feeder;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_full;
    logic          start = 1'b0;
    logic [3:0]    burst_len = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          err_clear = 1'b0;
    logic          busy;
    logic          done;
    logic          error;
`ifdef PIPELINE_FEEDER_STATS_EN
    logic [15:0]   sent_count;
`endif

    int total = 0;
    int bad   = 0;

    pipeline_feeder dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_full   (wr_full),
        .start     (start),
        .burst_len (burst_len),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .err_clear (err_clear),
        .busy      (busy),
        .done      (done),
`ifdef PIPELINE_FEEDER_STATS_EN
        .sent_count(sent_count),
`endif
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        wr_en = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        err_clear = 1'b0;
        tick;
        reset = 1'b0;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick;
        wr_en   = 1'b0;
    endtask

    task automatic start_burst(input logic [3:0] n);
        start     = 1'b1;
        burst_len = n;
        tick;
        start     = 1'b0;
        burst_len = '0;
    endtask

    task automatic test_reset;
        do_reset;
        total++;
        if ({out_valid, done, error, busy, wr_full} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=00000", {out_valid, done, error, busy, wr_full});
        end
        total++;
        if (out_data !== '0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=0", out_data);
        end
        start_burst(4'd0);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_len_start busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_basic;
        logic [DW-1:0] exp_d [3];
        exp_d[0] = 32'hA1; exp_d[1] = 32'hA2; exp_d[2] = 32'hA3;
        do_reset;
        for (int i = 0; i < 3; i++) write_word(exp_d[i]);
        out_ready = 1'b1;
        start_burst(4'd3);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin
                bad++;
                $display("FAIL basic_beat%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, exp_d[i]);
            end
            tick;
        end
        total++;
        if ({done, busy, out_valid} !== 3'b100) begin
            bad++;
            $display("FAIL basic_done got done/busy/valid=%b exp=100", {done, busy, out_valid});
        end
        tick;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_pulse got=%b exp=0", done);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_full;
        do_reset;
        for (int i = 0; i < 8; i++) write_word(32'h10 + DW'(i));
        total++;
        if (wr_full !== 1'b1) begin
            bad++;
            $display("FAIL full_flag got=%b exp=1", wr_full);
        end
        write_word(32'hFF);
        out_ready = 1'b1;
        start_burst(4'd8);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'h10 + DW'(i)) begin
                bad++;
                $display("FAIL full_beat%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, 32'h10 + DW'(i));
            end
            tick;
        end
        total++;
        if ({done, out_valid, wr_full} !== 3'b100) begin
            bad++;
            $display("FAIL full_after got done/valid/full=%b exp=100 (extra word leaked?)", {done, out_valid, wr_full});
        end
        out_ready = 1'b0;
    endtask

    task automatic test_starve;
        do_reset;
        write_word(32'hB1);
        write_word(32'hB2);
        out_ready = 1'b1;
        start_burst(4'd4);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'hB1 + DW'(i)) begin
                bad++;
                $display("FAIL starve_beat%0d got v=%b d=%h exp d=%h", i, out_valid, out_data, 32'hB1 + DW'(i));
            end
            tick;
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({out_valid, error, busy} !== 3'b001) begin
                bad++;
                $display("FAIL starve_wait%0d got valid/error/busy=%b exp=001", i, {out_valid, error, busy});
            end
            tick;
        end
        write_word(32'hB3);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hB3) begin
            bad++;
            $display("FAIL starve_b3 got v=%b d=%h exp v=1 d=b3", out_valid, out_data);
        end
        write_word(32'hB4);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hB4) begin
            bad++;
            $display("FAIL starve_b4 got v=%b d=%h exp v=1 d=b4", out_valid, out_data);
        end
        tick;
        total++;
        if ({done, busy, error} !== 3'b100) begin
            bad++;
            $display("FAIL starve_done got done/busy/error=%b exp=100", {done, busy, error});
        end
        out_ready = 1'b0;
    endtask

    task automatic test_timeout;
        do_reset;
        write_word(32'hC1);
        write_word(32'hC2);
        err_clear = 1'b1;
        tick;
        err_clear = 1'b0;
        start_burst(4'd2);
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({out_valid, error} !== 2'b10 || out_data !== 32'hC1) begin
                bad++;
                $display("FAIL stall_cycle%0d got v=%b e=%b d=%h exp v=1 e=0 d=c1", i, out_valid, error, out_data);
            end
            tick;
        end
        total++;
        if ({error, out_valid, busy} !== 3'b101) begin
            bad++;
            $display("FAIL timeout_error got error/valid/busy=%b exp=101", {error, out_valid, busy});
        end
        write_word(32'hEE);
        err_clear = 1'b1;
        tick;
        err_clear = 1'b0;
        total++;
        if ({error, busy, out_valid, wr_full} !== 4'b0000 || out_data !== '0) begin
            bad++;
            $display("FAIL err_clear got error/busy/valid/full=%b d=%h exp=0000 d=0", {error, busy, out_valid, wr_full}, out_data);
        end
        out_ready = 1'b1;
        start_burst(4'd1);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flushed_empty got valid=%b exp=0", out_valid);
        end
        write_word(32'hD1);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hD1) begin
            bad++;
            $display("FAIL post_clear_beat got v=%b d=%h exp v=1 d=d1", out_valid, out_data);
        end
        tick;
        total++;
        if ({done, busy} !== 2'b10) begin
            bad++;
            $display("FAIL post_clear_done got done/busy=%b exp=10", {done, busy});
        end
        out_ready = 1'b0;
    endtask

    task automatic test_toggle(input int stop_after);
        int idx;
        int cyc;
        do_reset;
        for (int i = 0; i < 5; i++) write_word(32'hE1 + DW'(i));
        start_burst(4'd5);
        idx = 0;
        cyc = 0;
        out_ready = 1'b1;
        while (idx < stop_after && cyc < 30) begin
            out_ready = ~out_ready;
            total++;
            if ({out_valid, error} !== 2'b10 || out_data !== 32'hE1 + DW'(idx)) begin
                bad++;
                $display("FAIL toggle_beat%0d got v=%b e=%b d=%h exp d=%h", idx, out_valid, error, out_data, 32'hE1 + DW'(idx));
            end
            if (out_ready) idx++;
            tick;
            cyc++;
        end
        out_ready = 1'b0;
        total++;
        if (idx != stop_after) begin
            bad++;
            $display("FAIL toggle_budget got beats=%0d exp=%0d", idx, stop_after);
        end
        if (stop_after == 5) begin
            total++;
            if ({done, busy, error} !== 3'b100) begin
                bad++;
                $display("FAIL toggle_done got done/busy/error=%b exp=100", {done, busy, error});
            end
        end else begin
            reset = 1'b1;
            tick;
            reset = 1'b0;
            total++;
            if ({out_valid, done, error, busy, wr_full} !== 5'b0 || out_data !== '0) begin
                bad++;
                $display("FAIL midburst_reset got flags=%b d=%h exp=00000 d=0", {out_valid, done, error, busy, wr_full}, out_data);
            end
            out_ready = 1'b1;
            start_burst(4'd3);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL midburst_discard got valid=%b exp=0", out_valid);
            end
            out_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back;
        do_reset;
        out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 4; i++) write_word(32'h100 * DW'(b + 1) + DW'(i));
            start_burst(4'd4);
            start     = 1'b1;
            burst_len = 4'd2;
            for (int i = 0; i < 4; i++) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== 32'h100 * DW'(b + 1) + DW'(i)) begin
                    bad++;
                    $display("FAIL b2b_burst%0d_beat%0d got v=%b d=%h", b, i, out_valid, out_data);
                end
                tick;
            end
            start     = 1'b0;
            burst_len = '0;
            total++;
            if ({done, busy} !== 2'b10) begin
                bad++;
                $display("FAIL b2b_burst%0d_end got done/busy=%b exp=10", b, {done, busy});
            end
        end
`ifdef PIPELINE_FEEDER_STATS_EN
        total++;
        if (sent_count !== 16'd12) begin
            bad++;
            $display("FAIL sent_count got=%0d exp=12", sent_count);
        end
`endif
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_full;
        test_starve;
        test_timeout;
        test_toggle(5);
        test_toggle(2);
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_feeder.md
PIPELINE_FEEDER -- requirements
Module: pipeline_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of data words.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, number of buffered words (power of two, >=2).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 10, ready-stall cycles that trigger error.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port wr_en  input  1  load one word into FIFO.
REQ-007 SHALL have port wr_data  input  DATA_WIDTH  word to load.
REQ-008 SHALL have port wr_full  output  1  FIFO holds FIFO_DEPTH words.
REQ-009 SHALL have port start  input  1  begin a burst, sampled only in IDLE.
REQ-010 SHALL have port burst_len  input  $clog2(FIFO_DEPTH+1)  beats in burst, sampled with start.
REQ-011 SHALL have port out_valid  output  1  beat offered downstream.
REQ-012 SHALL have port out_data  output  DATA_WIDTH  beat payload.
REQ-013 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-014 SHALL have port err_clear  input  1  leave ERROR, flush FIFO.
REQ-015 SHALL have ports busy, done, error  output  1 each  state not IDLE / one-cycle burst-complete pulse / sticky stall timeout.

Function
REQ-016 SHALL implement states IDLE, SEND, ERROR; busy = (state != IDLE).
REQ-017 SHALL in IDLE on start with burst_len != 0 load beat counter with burst_len and enter SEND next cycle; start with burst_len == 0 ignored.
REQ-018 SHALL drive out_valid = (state == SEND) and FIFO not empty; out_data = FIFO head word.
REQ-019 SHALL transfer a beat when out_valid && out_ready: pop FIFO, decrement beat counter.
REQ-020 SHALL, once out_valid asserts, hold out_valid high and out_data stable until handshake or entry to ERROR.
REQ-021 SHALL, on handshake of the last beat (counter == 1), return to IDLE and assert done for exactly the following cycle.
REQ-022 SHALL write wr_data on wr_en when not full in any state except ERROR; word visible at head the cycle after write if FIFO was empty.
REQ-023 SHALL ignore wr_en when full, even if a pop occurs the same cycle; simultaneous write and pop when not full SHALL keep occupancy unchanged.
REQ-024 SHALL wrap read/write pointers modulo FIFO_DEPTH; full/empty distinguished by an occupancy count 0..FIFO_DEPTH.
REQ-025 SHALL, in SEND with FIFO empty (starvation), wait without timeout and without error.
REQ-026 SHALL count consecutive cycles with out_valid && !out_ready, reset to 0 on handshake or when out_valid low, saturating at TIMEOUT_CYCLES.
REQ-027 SHALL enter ERROR when the stall count reaches TIMEOUT_CYCLES; in ERROR out_valid = 0, error = 1, wr_en ignored.
REQ-028 SHALL in ERROR on err_clear flush FIFO, zero counters, deassert error and enter IDLE next cycle; err_clear outside ERROR ignored.
REQ-029 SHALL keep start ignored while busy.

Reset
REQ-030 SHALL on reset enter IDLE, empty FIFO, zero pointers, beat and stall counters; out_valid, done, error, busy = 0, wr_full = 0, out_data = 0.
REQ-031 SHALL honour reset mid-burst or in ERROR identically, discarding pending beats.

Configuration
REQ-032 SHALL, with PIPELINE_FEEDER_STATS_EN defined, add output sent_count (16 bits): total accepted beats since reset, wrapping 0xFFFF->0, cleared by reset only.
REQ-033 SHALL, without PIPELINE_FEEDER_STATS_EN, omit sent_count and its logic; all other behaviour identical.

Verification
REQ-034 Write 0xA1,0xA2,0xA3; start, burst_len=3, out_ready=1 -> out_data 0xA1,0xA2,0xA3 on three consecutive cycles, done pulse one cycle after last, busy low.
REQ-035 Write 8 words -> wr_full=1; 9th write 0xFF ignored; burst of 8 sends original 8 words only.
REQ-036 start burst_len=4 with 2 words loaded -> 2 beats sent, out_valid low while empty, no error; write 2 more -> remaining beats sent, done.
REQ-037 Burst started, out_ready held 0 -> out_valid stable 10 cycles, then ERROR, error=1, out_valid=0; err_clear -> IDLE, FIFO empty, error=0.
REQ-038 out_ready toggled 1/0 each cycle over burst_len=5 with 9 stall cycles max -> no error, all 5 beats in order; reset asserted after beat 2 -> all outputs at reset values next cycle.
REQ-039 With PIPELINE_FEEDER_STATS_EN: 3 bursts of 4 -> sent_count = 12.
